// File: rtl/memory_stage_pkg.sv
// Shared types and widths for the memory stage: FSM state encoding and datapath widths.
package memory_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Word accesses only: any set low address bit means a misaligned word.
    function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access controller: IDLE/REQ handshake FSM plus the access latches.
// Optional feature: MEM_ALIGN_CHECK_EN rejects misaligned word accesses with a one-cycle flag.
module mem_access_fsm
    import memory_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_mem_readmem,
    input  logic              ex_mem_writemem,
    input  logic [DATA_W-1:0] ex_mem_regb,
    input  logic              ex_mem_selwsource,
    input  logic [REG_W-1:0]  ex_mem_regdest,
    input  logic              ex_mem_writereg,
    input  logic [DATA_W-1:0] ex_mem_wbvalue,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              mem_stall,
    output logic              mem_misalign,
    output logic              in_req,
    output logic              idle_access,
    output logic [REG_W-1:0]  held_regdest,
    output logic              held_writereg,
    output logic              held_selwsource,
    output logic              held_we,
    output logic [DATA_W-1:0] held_addr
);

    state_t            state;
    state_t            next_state;
    logic              access;
    logic              misaligned;
    logic [DATA_W-1:0] held_wdata;

    assign access = ex_mem_readmem | ex_mem_writemem;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    assign misaligned   = access & is_misaligned(ex_mem_wbvalue);
    assign mem_misalign = misalign_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state == IDLE) & misaligned;
        end
    end
`else
    assign misaligned   = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_stall  = 1'b0;
        unique case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    next_state = REQ;
                    mem_stall  = 1'b1;
                end
            end
            REQ: begin
                mem_stall = ~dmem_ack;
                if (dmem_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the access once, in the IDLE cycle that issues it; writemem wins over readmem.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_addr       <= '0;
            held_wdata      <= '0;
            held_we         <= 1'b0;
            held_regdest    <= '0;
            held_writereg   <= 1'b0;
            held_selwsource <= 1'b0;
        end else if (state == IDLE && access && !misaligned) begin
            held_addr       <= ex_mem_wbvalue;
            held_wdata      <= ex_mem_regb;
            held_we         <= ex_mem_writemem;
            held_regdest    <= ex_mem_regdest;
            held_writereg   <= ex_mem_writereg;
            held_selwsource <= ex_mem_selwsource;
        end
    end

    assign in_req      = (state == REQ);
    assign idle_access = (state == IDLE) & access;
    assign dmem_req    = in_req;
    assign dmem_we     = held_we;
    assign dmem_addr   = held_addr;
    assign dmem_wdata  = held_wdata;

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: drives the data-memory handshake and owns the MEM/WB register.
// Optional feature: MEM_ALIGN_CHECK_EN (misaligned accesses are dropped and flagged).
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_mem_readmem,
    input  logic              ex_mem_writemem,
    input  logic [DATA_W-1:0] ex_mem_regb,
    input  logic              ex_mem_selwsource,
    input  logic [REG_W-1:0]  ex_mem_regdest,
    input  logic              ex_mem_writereg,
    input  logic [DATA_W-1:0] ex_mem_wbvalue,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic              mem_misalign,
    output logic [REG_W-1:0]  mem_wb_regdest,
    output logic              mem_wb_writereg,
    output logic [DATA_W-1:0] mem_wb_wbvalue
);

    logic              in_req;
    logic              idle_access;
    logic [REG_W-1:0]  held_regdest;
    logic              held_writereg;
    logic              held_selwsource;
    logic              held_we;
    logic [DATA_W-1:0] held_addr;

    mem_access_fsm u_fsm (
        .clock             (clock),
        .reset             (reset),
        .ex_mem_readmem    (ex_mem_readmem),
        .ex_mem_writemem   (ex_mem_writemem),
        .ex_mem_regb       (ex_mem_regb),
        .ex_mem_selwsource (ex_mem_selwsource),
        .ex_mem_regdest    (ex_mem_regdest),
        .ex_mem_writereg   (ex_mem_writereg),
        .ex_mem_wbvalue    (ex_mem_wbvalue),
        .dmem_ack          (dmem_ack),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .mem_stall         (mem_stall),
        .mem_misalign      (mem_misalign),
        .in_req            (in_req),
        .idle_access       (idle_access),
        .held_regdest      (held_regdest),
        .held_writereg     (held_writereg),
        .held_selwsource   (held_selwsource),
        .held_we           (held_we),
        .held_addr         (held_addr)
    );

    // Any cycle that does not complete an instruction writes a bubble (writereg=0);
    // regdest/wbvalue keep their last values since they are ignored without writereg.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_wb_regdest  <= '0;
            mem_wb_writereg <= 1'b0;
            mem_wb_wbvalue  <= '0;
        end else if (in_req) begin
            if (dmem_ack) begin
                mem_wb_regdest  <= held_regdest;
                mem_wb_writereg <= held_writereg & ~held_we;
                mem_wb_wbvalue  <= held_selwsource ? dmem_rdata : held_addr;
            end else begin
                mem_wb_writereg <= 1'b0;
            end
        end else if (idle_access) begin
            mem_wb_writereg <= 1'b0;
        end else begin
            mem_wb_regdest  <= ex_mem_regdest;
            mem_wb_writereg <= ex_mem_writereg;
            mem_wb_wbvalue  <= ex_mem_wbvalue;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: transaction-level model compared every cycle plus directed literal checks.
// Expectations follow MEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_memory_stage;
    import memory_stage_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_mem_readmem = 1'b0;
    logic        ex_mem_writemem = 1'b0;
    logic [31:0] ex_mem_regb = '0;
    logic        ex_mem_selwsource = 1'b0;
    logic [4:0]  ex_mem_regdest = '0;
    logic        ex_mem_writereg = 1'b0;
    logic [31:0] ex_mem_wbvalue = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        mem_stall;
    logic        mem_misalign;
    logic [4:0]  mem_wb_regdest;
    logic        mem_wb_writereg;
    logic [31:0] mem_wb_wbvalue;

    memory_stage dut (
        .clock             (clock),
        .reset             (reset),
        .ex_mem_readmem    (ex_mem_readmem),
        .ex_mem_writemem   (ex_mem_writemem),
        .ex_mem_regb       (ex_mem_regb),
        .ex_mem_selwsource (ex_mem_selwsource),
        .ex_mem_regdest    (ex_mem_regdest),
        .ex_mem_writereg   (ex_mem_writereg),
        .ex_mem_wbvalue    (ex_mem_wbvalue),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_rdata        (dmem_rdata),
        .dmem_ack          (dmem_ack),
        .mem_stall         (mem_stall),
        .mem_misalign      (mem_misalign),
        .mem_wb_regdest    (mem_wb_regdest),
        .mem_wb_writereg   (mem_wb_writereg),
        .mem_wb_wbvalue    (mem_wb_wbvalue)
    );

    always #5 clock = ~clock;

    int total_checks = 0;
    int bad_checks   = 0;
    int stall_cycles = 0;
    int req_cycles   = 0;
    logic [31:0] last_req_addr  = '0;
    logic [31:0] last_req_wdata = '0;
    logic        last_req_we    = 1'b0;

    // Model: at most one outstanding memory transaction, plus the expected MEM/WB contents.
    bit          pend_valid;
    logic [31:0] pend_addr, pend_wdata;
    bit          pend_we, pend_wr, pend_sel;
    logic [4:0]  pend_rd;
    logic [4:0]  exp_wb_rd;
    bit          exp_wb_wr;
    logic [31:0] exp_wb_val;
    bit          exp_misalign;
    bit          m_acc, m_mis, c_acc, c_mis;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid   = 0;
            pend_addr    = '0;
            pend_wdata   = '0;
            pend_we      = 0;
            pend_wr      = 0;
            pend_sel     = 0;
            pend_rd      = '0;
            exp_wb_rd    = '0;
            exp_wb_wr    = 0;
            exp_wb_val   = '0;
            exp_misalign = 0;
        end else begin
            m_acc = ex_mem_readmem || ex_mem_writemem;
            m_mis = ALIGN_CHECK && m_acc && (ex_mem_wbvalue[1:0] != 2'b00);
            exp_misalign = 0;
            if (pend_valid) begin
                if (dmem_ack) begin
                    exp_wb_rd  = pend_rd;
                    exp_wb_wr  = pend_wr && !pend_we;
                    exp_wb_val = pend_sel ? dmem_rdata : pend_addr;
                    pend_valid = 0;
                end else begin
                    exp_wb_wr = 0;
                end
            end else if (m_mis) begin
                exp_wb_wr    = 0;
                exp_misalign = 1;
            end else if (m_acc) begin
                pend_valid = 1;
                pend_addr  = ex_mem_wbvalue;
                pend_wdata = ex_mem_regb;
                pend_we    = ex_mem_writemem;
                pend_wr    = ex_mem_writereg;
                pend_sel   = ex_mem_selwsource;
                pend_rd    = ex_mem_regdest;
                exp_wb_wr  = 0;
            end else begin
                exp_wb_rd  = ex_mem_regdest;
                exp_wb_wr  = ex_mem_writereg;
                exp_wb_val = ex_mem_wbvalue;
            end
        end
    end

    // Compare every cycle at the falling edge, when inputs and combinational outputs are settled.
    always @(negedge clock) begin
        if (!reset) begin
            c_acc = ex_mem_readmem || ex_mem_writemem;
            c_mis = ALIGN_CHECK && c_acc && (ex_mem_wbvalue[1:0] != 2'b00);
            checkOutput("dmem_req", {31'b0, dmem_req}, {31'b0, pend_valid});
            if (pend_valid) begin
                checkOutput("dmem_we", {31'b0, dmem_we}, {31'b0, pend_we});
                checkOutput("dmem_addr", dmem_addr, pend_addr);
                checkOutput("dmem_wdata", dmem_wdata, pend_wdata);
                checkOutput("mem_stall", {31'b0, mem_stall}, {31'b0, !dmem_ack});
            end else begin
                checkOutput("mem_stall", {31'b0, mem_stall}, {31'b0, c_acc && !c_mis});
            end
            checkOutput("mem_misalign", {31'b0, mem_misalign}, {31'b0, exp_misalign});
            checkOutput("mem_wb_regdest", {27'b0, mem_wb_regdest}, {27'b0, exp_wb_rd});
            checkOutput("mem_wb_writereg", {31'b0, mem_wb_writereg}, {31'b0, exp_wb_wr});
            checkOutput("mem_wb_wbvalue", mem_wb_wbvalue, exp_wb_val);
            if (mem_stall) stall_cycles++;
            if (dmem_req) begin
                req_cycles++;
                last_req_addr  = dmem_addr;
                last_req_wdata = dmem_wdata;
                last_req_we    = dmem_we;
            end
        end
    end

    task automatic setNop();
        ex_mem_readmem  = 0;
        ex_mem_writemem = 0;
        ex_mem_writereg = 0;
        ex_mem_regb     = '0;
        ex_mem_selwsource = 0;
    endtask

    // Called just after a rising edge; plays one instruction including its memory responder side.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] regb, input logic sel,
                                 input logic [4:0] dest, input logic wreg, input logic [31:0] val,
                                 input int waits, input logic [31:0] rdata);
        ex_mem_readmem    = rd;
        ex_mem_writemem   = wr;
        ex_mem_regb       = regb;
        ex_mem_selwsource = sel;
        ex_mem_regdest    = dest;
        ex_mem_writereg   = wreg;
        ex_mem_wbvalue    = val;
        if ((rd || wr) && !(ALIGN_CHECK && val[1:0] != 2'b00)) begin
            @(posedge clock); #1;
            dmem_ack = 0;
            repeat (waits) begin
                @(posedge clock); #1;
            end
            dmem_ack   = 1;
            dmem_rdata = rdata;
            @(posedge clock); #1;
            dmem_ack   = 0;
            dmem_rdata = '0;
            setNop();
        end else begin
            @(posedge clock); #1;
        end
    endtask

    task automatic clearCounters();
        stall_cycles = 0;
        req_cycles   = 0;
    endtask

    initial begin
        #7;
        checkOutput("reset_req", {31'b0, dmem_req}, 32'h0);
        checkOutput("reset_misalign", {31'b0, mem_misalign}, 32'h0);
        checkOutput("reset_wb_wr", {31'b0, mem_wb_writereg}, 32'h0);
        checkOutput("reset_wb_val", mem_wb_wbvalue, 32'h0);
        #5 reset = 0;
        @(posedge clock); #1;

        clearCounters();
        applyStimulus(0, 0, 32'h0, 0, 5'd5, 1, 32'h0000_1234, 0, 32'h0);
        checkOutput("alu_val", mem_wb_wbvalue, 32'h0000_1234);
        checkOutput("alu_wr", {31'b0, mem_wb_writereg}, 32'h1);
        checkOutput("alu_rd", {27'b0, mem_wb_regdest}, 32'd5);
        checkOutput("alu_stall_cycles", stall_cycles, 32'd0);

        clearCounters();
        dmem_ack   = 1;
        dmem_rdata = 32'hFFFF_FFFF;
        applyStimulus(0, 0, 32'h0, 0, 5'd7, 1, 32'h0000_0055, 0, 32'h0);
        dmem_ack   = 0;
        dmem_rdata = '0;
        checkOutput("idle_ack_val", mem_wb_wbvalue, 32'h0000_0055);
        checkOutput("idle_ack_req_cycles", req_cycles, 32'd0);

        clearCounters();
        applyStimulus(1, 0, 32'h0, 1, 5'd9, 1, 32'h0000_0100, 0, 32'hDEAD_BEEF);
        checkOutput("load0_val", mem_wb_wbvalue, 32'hDEAD_BEEF);
        checkOutput("load0_wr", {31'b0, mem_wb_writereg}, 32'h1);
        checkOutput("load0_rd", {27'b0, mem_wb_regdest}, 32'd9);
        checkOutput("load0_stall_cycles", stall_cycles, 32'd1);
        checkOutput("load0_req_cycles", req_cycles, 32'd1);

        clearCounters();
        applyStimulus(1, 0, 32'h0, 0, 5'd3, 1, 32'h0000_0300, 1, 32'h1111_1111);
        checkOutput("load_addr_val", mem_wb_wbvalue, 32'h0000_0300);
        checkOutput("load_addr_stall_cycles", stall_cycles, 32'd2);

        clearCounters();
        applyStimulus(0, 1, 32'hA5A5_A5A5, 0, 5'd4, 1, 32'h0000_0200, 3, 32'h0);
        checkOutput("store_req_cycles", req_cycles, 32'd4);
        checkOutput("store_stall_cycles", stall_cycles, 32'd4);
        checkOutput("store_addr", last_req_addr, 32'h0000_0200);
        checkOutput("store_wdata", last_req_wdata, 32'hA5A5_A5A5);
        checkOutput("store_wb_wr", {31'b0, mem_wb_writereg}, 32'h0);

        clearCounters();
        applyStimulus(1, 1, 32'h0000_0077, 0, 5'd6, 1, 32'h0000_0400, 0, 32'h9999_9999);
        checkOutput("both_we", {31'b0, last_req_we}, 32'h1);
        checkOutput("both_wb_wr", {31'b0, mem_wb_writereg}, 32'h0);

        clearCounters();
        applyStimulus(1, 0, 32'h0, 1, 5'd8, 1, 32'h0000_0102, 0, 32'h4242_4242);
        if (ALIGN_CHECK) begin
            checkOutput("misalign_flag", {31'b0, mem_misalign}, 32'h1);
            checkOutput("misalign_req_cycles", req_cycles, 32'd0);
            checkOutput("misalign_stall_cycles", stall_cycles, 32'd0);
            checkOutput("misalign_wb_wr", {31'b0, mem_wb_writereg}, 32'h0);
            setNop();
            @(posedge clock); #1;
            checkOutput("misalign_pulse_end", {31'b0, mem_misalign}, 32'h0);
        end else begin
            checkOutput("noalign_addr", last_req_addr, 32'h0000_0102);
            checkOutput("noalign_flag", {31'b0, mem_misalign}, 32'h0);
            checkOutput("noalign_val", mem_wb_wbvalue, 32'h4242_4242);
        end

        // Reset in the middle of a waiting store.
        ex_mem_writemem = 1;
        ex_mem_regb     = 32'h1357_9BDF;
        ex_mem_wbvalue  = 32'h0000_0500;
        ex_mem_regdest  = 5'd2;
        @(posedge clock); #1;
        setNop();
        dmem_ack = 0;
        #2;
        checkOutput("midreq_req_before", {31'b0, dmem_req}, 32'h1);
        reset = 1;
        #1;
        checkOutput("midreq_req_dropped", {31'b0, dmem_req}, 32'h0);
        checkOutput("midreq_stall", {31'b0, mem_stall}, 32'h0);
        checkOutput("midreq_wb_rd", {27'b0, mem_wb_regdest}, 32'h0);
        checkOutput("midreq_wb_wr", {31'b0, mem_wb_writereg}, 32'h0);
        checkOutput("midreq_wb_val", mem_wb_wbvalue, 32'h0);
        #3 reset = 0;
        clearCounters();
        repeat (3) begin
            @(posedge clock); #1;
        end
        checkOutput("no_retry_req_cycles", req_cycles, 32'd0);

        applyStimulus(0, 0, 32'h0, 0, 5'd31, 1, 32'hCAFE_F00D, 0, 32'h0);
        checkOutput("recover_val", mem_wb_wbvalue, 32'hCAFE_F00D);
        checkOutput("recover_rd", {27'b0, mem_wb_regdest}, 32'd31);
        setNop();
        @(posedge clock); #1;

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset; polarity and synchronicity are fixed.
REQ-002 The block SHALL expose these ports (name direction width meaning):
- clock in 1 rising-edge clock
- reset in 1 async active-high reset
- ex_mem_readmem in 1 load request
- ex_mem_writemem in 1 store request
- ex_mem_regb in 32 store data
- ex_mem_selwsource in 1 1 = writeback from memory data
- ex_mem_regdest in 5 destination register
- ex_mem_writereg in 1 register write enable
- ex_mem_wbvalue in 32 ALU result; also the memory address
- dmem_req out 1 data-memory request
- dmem_we out 1 1 = write
- dmem_addr out 32 word address (byte-addressed)
- dmem_wdata out 32 store data
- dmem_rdata in 32 load data, valid with dmem_ack
- dmem_ack in 1 access complete
- mem_stall out 1 freeze EX/MEM register and upstream
- mem_misalign out 1 one-cycle misalignment flag
- mem_wb_regdest out 5 registered destination
- mem_wb_writereg out 1 registered write enable
- mem_wb_wbvalue out 32 registered writeback value

Function
REQ-003 The FSM SHALL have two states, IDLE and REQ, and reset to IDLE.
REQ-004 In IDLE with no access (readmem=0, writemem=0), the block SHALL register mem_wb_* <= ex_mem_regdest/writereg/wbvalue at the next edge (1-cycle latency), with mem_stall=0.
REQ-005 In IDLE with an access, mem_stall SHALL be 1 combinationally.
REQ-006 In that IDLE access cycle, the block SHALL latch addr=ex_mem_wbvalue, wdata=ex_mem_regb, we=ex_mem_writemem, regdest, writereg and selwsource, go to REQ, and register mem_wb_writereg=0 (bubble).
REQ-007 In REQ, dmem_req SHALL be 1 and dmem_addr/dmem_wdata/dmem_we SHALL be driven from the latches, stable until ack; mem_stall SHALL equal !dmem_ack.
REQ-008 On dmem_ack in REQ for a load, the block SHALL register mem_wb_wbvalue = selwsource ? dmem_rdata : latched addr, mem_wb_writereg = latched writereg and mem_wb_regdest = latched regdest, then return to IDLE.
REQ-009 On dmem_ack in REQ for a store, mem_wb_writereg SHALL be 0.
REQ-010 Load latency from the IDLE access cycle to valid mem_wb_* SHALL be 2+N cycles, where N is the number of REQ cycles without ack.
REQ-011 While in REQ without ack, mem_wb_writereg SHALL be 0 each cycle.
REQ-012 dmem_ack SHALL be ignored in IDLE.
REQ-013 dmem_req SHALL be 0 in IDLE.
REQ-014 If readmem and writemem are both 1, the access SHALL be treated as a store.
REQ-015 Accesses SHALL be 32-bit words only; no byte enables.

Reset
REQ-016 reset SHALL, immediately and asynchronously, force state=IDLE, dmem_req=0, mem_misalign=0, all latches=0, mem_wb_regdest=0, mem_wb_writereg=0 and mem_wb_wbvalue=0, including mid-access.
REQ-017 An access aborted by reset SHALL NOT be retried.

Configuration
REQ-018 With MEM_ALIGN_CHECK_EN defined, an IDLE access with ex_mem_wbvalue[1:0]!=0 SHALL issue no request, keep mem_stall=0, register mem_wb_writereg=0 and mem_misalign=1 for one cycle, and stay in IDLE.
REQ-019 Without MEM_ALIGN_CHECK_EN, mem_misalign SHALL be tied 0 and the address SHALL be forwarded unchanged.

Structure
REQ-020 A shared package SHALL hold the FSM state type (IDLE, REQ), DATA_W=32 and REG_W=5.
REQ-021 One sub-module, mem_access_fsm (state, latches, handshake), SHALL be used; the pipeline register SHALL stay in memory_stage.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
- ALU op: wbvalue=0x0000_1234, regdest=5, writereg=1 -> next cycle mem_wb_wbvalue=0x1234, writereg=1, stall never high.
- Load, zero wait: addr=0x100, selwsource=1, ack in first REQ cycle, rdata=0xDEAD_BEEF -> stall high 1 cycle; mem_wb value=0xDEADBEEF 2 cycles after issue.
- Store with 3 wait cycles: addr=0x200, regb=0xA5A5_A5A5 -> dmem_req/we/addr/wdata stable 4 cycles; stall high 4 cycles; mem_wb_writereg=0 throughout.
- Reset mid-REQ -> dmem_req drops with no clock edge; state IDLE; all mem_wb_* = 0.
- readmem=writemem=1 -> dmem_we=1.
- MEM_ALIGN_CHECK_EN, load addr=0x102 -> no dmem_req, mem_misalign pulse of 1 cycle, writereg=0; without the macro -> dmem_addr=0x102.
